// File: rtl/cpu_pkg.sv
// Shared definitions for the single-bus CPU datapath: ALU opcodes, IR field
// positions and the default RAM depth.
package cpu_pkg;

    localparam int MEM_DEPTH_DEF = 512;
    localparam int NUM_REGS      = 16;
    localparam int R8_IDX        = 8;

    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;
    localparam int C_MSB  = 18;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    function automatic logic [31:0] sext_c(input logic [C_MSB:0] c);
        return {{(31 - C_MSB){c[C_MSB]}}, c};
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: A comes from Y, B from the bus, 64-bit result feeds Z.
module alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  opcode,
    output logic [63:0] result
);

    logic [4:0]         shamt_s;
    logic [31:0]        sum_s;
    logic [63:0]        rot_r_s;
    logic [63:0]        rot_l_s;
    logic signed [31:0] as_s;
    logic signed [31:0] bs_s;
    logic signed [31:0] sra_s;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic signed [63:0] prod_s;

    assign shamt_s = b[4:0];
    assign sum_s   = a + b;
    assign as_s    = a;
    assign bs_s    = b;
    // Rotates are taken from a doubled copy of A so no wrap logic is needed.
    assign rot_r_s = {a, a} >> shamt_s;
    assign rot_l_s = {a, a} << shamt_s;
    assign sra_s   = as_s >>> shamt_s;
    assign quo_s   = as_s / bs_s;
    assign rem_s   = as_s % bs_s;
    assign prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

    // Operation select; unknown opcodes fall back to addition.
    always_comb begin
        result = {32'd0, sum_s};
        case (opcode)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: result = {32'd0, sum_s};
            OP_SUB:          result = {32'd0, a - b};
            OP_AND, OP_ANDI: result = {32'd0, a & b};
            OP_OR, OP_ORI:   result = {32'd0, a | b};
            OP_ROR:          result = {32'd0, rot_r_s[31:0]};
            OP_ROL:          result = {32'd0, rot_l_s[63:32]};
            OP_SHR:          result = {32'd0, a >> shamt_s};
            OP_SHRA:         result = {32'd0, sra_s};
            OP_SHL:          result = {32'd0, a << shamt_s};
            OP_DIV: begin
                if (b == 32'd0) begin
                    result = {a, 32'hFFFF_FFFF};
                end else begin
                    result = {rem_s, quo_s};
                end
            end
            OP_MUL:          result = prod_s;
            OP_NEG:          result = {32'd0, 32'd0 - b};
            OP_NOT:          result = {32'd0, ~b};
            default:         result = {32'd0, sum_s};
        endcase
    end

endmodule

// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath; every storage element updates on the
// falling clock edge under direct control-unit strobes.
module data_path
    import cpu_pkg::*;
#(
    parameter int    MEM_DEPTH     = MEM_DEPTH_DEF,
    parameter string MEM_INIT_FILE = ""
) (
    input logic       clock,
    input logic       clear,
    input logic       read,
    input logic       write,
    input logic       Gra,
    input logic       Grb,
    input logic       Grc,
    input logic       Rin,
    input logic       Rout,
    input logic       BAout,
    input logic       HIout,
    input logic       HIin,
    input logic       LOout,
    input logic       LOin,
    input logic       Zhighout,
    input logic       Zlowout,
    input logic       Zin,
    input logic       Yin,
    input logic       MDRout,
    input logic       MDRin,
    input logic       MARin,
    input logic       PCout,
    input logic       PCin,
    input logic       IncPC,
    input logic       IRin,
    input logic       Cout,
    input logic       R8_RAin,
    input logic [4:0] opcode
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);

    logic [31:0] regs_r [NUM_REGS];
    logic [31:0] ram_r  [MEM_DEPTH];
    logic [31:0] pc_r, ir_r, mar_r, mdr_r, y_r, hi_r, lo_r;
    logic [63:0] z_r;

    logic [31:0]         bus_s;
    logic [31:0]         reg_rdata_s;
    logic [31:0]         ram_rdata_s;
    logic [31:0]         c_sext_s;
    logic [31:0]         mdr_next_s;
    logic [63:0]         alu_result_s;
    logic [3:0]          reg_idx_s;
    logic [NUM_REGS-1:0] reg_wr_s;
    logic [ADDR_W-1:0]   ram_addr_s;
    logic                unused_bits_s;

    assign reg_idx_s = ({4{Gra}} & ir_r[RA_MSB:RA_LSB])
                     | ({4{Grb}} & ir_r[RB_MSB:RB_LSB])
                     | ({4{Grc}} & ir_r[RC_MSB:RC_LSB]);
    assign c_sext_s      = sext_c(ir_r[C_MSB:0]);
    assign ram_addr_s    = mar_r[ADDR_W-1:0];
    assign ram_rdata_s   = ram_r[ram_addr_s];
    assign unused_bits_s = ^{ir_r[31:27], mar_r[31:ADDR_W]};

    // Register write decode; R8_RAin is an extra write port onto R8.
    always_comb begin
        reg_wr_s = '0;
        if (Rin) begin
            reg_wr_s = 16'd1 << reg_idx_s;
        end else begin
            reg_wr_s = '0;
        end
        reg_wr_s[R8_IDX] = reg_wr_s[R8_IDX] | R8_RAin;
    end

    // Register read; BAout treats R0 as a hard zero for base addressing.
    always_comb begin
        reg_rdata_s = regs_r[reg_idx_s];
        if (BAout && (reg_idx_s == 4'd0)) begin
            reg_rdata_s = 32'd0;
        end else begin
            reg_rdata_s = regs_r[reg_idx_s];
        end
    end

    // Bus priority mux.
    always_comb begin
        bus_s = 32'd0;
        if (Rout || BAout) begin
            bus_s = reg_rdata_s;
        end else if (HIout) begin
            bus_s = hi_r;
        end else if (LOout) begin
            bus_s = lo_r;
        end else if (Zhighout) begin
            bus_s = z_r[63:32];
        end else if (Zlowout) begin
            bus_s = z_r[31:0];
        end else if (PCout) begin
            bus_s = pc_r;
        end else if (MDRout) begin
            bus_s = mdr_r;
        end else if (Cout) begin
            bus_s = c_sext_s;
        end else begin
            bus_s = 32'd0;
        end
    end

    // MDR input mux.
    always_comb begin
        mdr_next_s = bus_s;
        if (read) begin
            mdr_next_s = ram_rdata_s;
        end else begin
            mdr_next_s = bus_s;
        end
    end

    alu u_alu (
        .a      (y_r),
        .b      (bus_s),
        .opcode (opcode),
        .result (alu_result_s)
    );

    // General-purpose register file.
    always_ff @(negedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_wr_s[i]) begin
                    regs_r[i] <= bus_s;
                end
            end
        end
    end

    // Special-purpose registers; PCin overrides IncPC.
    always_ff @(negedge clock or posedge clear) begin
        if (clear) begin
            pc_r  <= 32'd0;
            ir_r  <= 32'd0;
            mar_r <= 32'd0;
            mdr_r <= 32'd0;
            y_r   <= 32'd0;
            z_r   <= 64'd0;
            hi_r  <= 32'd0;
            lo_r  <= 32'd0;
        end else begin
            if (PCin) begin
                pc_r <= bus_s;
            end else if (IncPC) begin
                pc_r <= pc_r + 32'd1;
            end
            if (IRin)  ir_r  <= bus_s;
            if (MARin) mar_r <= bus_s;
            if (MDRin) mdr_r <= mdr_next_s;
            if (Yin)   y_r   <= bus_s;
            if (Zin)   z_r   <= alu_result_s;
            if (HIin)  hi_r  <= bus_s;
            if (LOin)  lo_r  <= bus_s;
        end
    end

    // RAM write port; a same-edge MDR load still sees the old word.
    always_ff @(negedge clock) begin
        if (write) begin
            ram_r[ram_addr_s] <= mdr_r;
        end
    end

    // Power-up RAM contents.
    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) begin
            ram_r[i] = 32'd0;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path; constants are synthesised through the ALU
// (shift-left / or with PC=1) since the datapath has no external data input.
module tb_data_path;

    logic clock, clear, read, write, Gra, Grb, Grc, Rin, Rout, BAout;
    logic HIout, HIin, LOout, LOin, Zhighout, Zlowout, Zin, Yin;
    logic MDRout, MDRin, MARin, PCout, PCin, IncPC, IRin, Cout, R8_RAin;
    logic [4:0] opcode;

    int vectors = 0;
    int miscompares = 0;

    data_path dut (
        .clock(clock), .clear(clear), .read(read), .write(write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .HIout(HIout), .HIin(HIin), .LOout(LOout), .LOin(LOin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .Zin(Zin), .Yin(Yin),
        .MDRout(MDRout), .MDRin(MDRin), .MARin(MARin), .PCout(PCout),
        .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .Cout(Cout),
        .R8_RAin(R8_RAin), .opcode(opcode)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic clr_ctrl();
        read = 0; write = 0; Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0;
        BAout = 0; HIout = 0; HIin = 0; LOout = 0; LOin = 0; Zhighout = 0;
        Zlowout = 0; Zin = 0; Yin = 0; MDRout = 0; MDRin = 0; MARin = 0;
        PCout = 0; PCin = 0; IncPC = 0; IRin = 0; Cout = 0; R8_RAin = 0;
        opcode = 5'b00000;
    endtask

    task automatic begin_cyc();
        @(posedge clock); #1; clr_ctrl();
    endtask

    task automatic end_cyc();
        @(negedge clock); #1; clr_ctrl();
    endtask

    // Leaves v in Z[31:0]; clobbers PC, Y and Z.
    task automatic build_z(input logic [31:0] v);
        begin_cyc(); PCin = 1; end_cyc();
        begin_cyc(); IncPC = 1; end_cyc();
        begin_cyc(); opcode = 5'b00101; Zin = 1; end_cyc();
        for (int i = 31; i >= 0; i--) begin
            begin_cyc(); Zlowout = 1; Yin = 1; end_cyc();
            begin_cyc(); PCout = 1; opcode = 5'b01011; Zin = 1; end_cyc();
            if (v[i]) begin
                begin_cyc(); Zlowout = 1; Yin = 1; end_cyc();
                begin_cyc(); PCout = 1; opcode = 5'b00110; Zin = 1; end_cyc();
            end
        end
    endtask

    task automatic test_reset();
        build_z(32'hA5A5_0001);
        begin_cyc();
        Zlowout = 1; MDRin = 1; Yin = 1; HIin = 1; LOin = 1; MARin = 1;
        IRin = 1; Gra = 1; Rin = 1; R8_RAin = 1; IncPC = 1;
        end_cyc();
        vectors++; if (dut.hi_r !== 32'hA5A5_0001) begin miscompares++; $display("FAIL preload_hi: got %h want %h", dut.hi_r, 32'hA5A5_0001); end
        vectors++; if (dut.pc_r !== 32'd2) begin miscompares++; $display("FAIL preload_pc: got %h want %h", dut.pc_r, 32'd2); end
        @(posedge clock); #2; clear = 1; #1;
        vectors++; if (dut.pc_r !== 32'd0) begin miscompares++; $display("FAIL rst_pc: got %h want 0", dut.pc_r); end
        vectors++; if (dut.ir_r !== 32'd0) begin miscompares++; $display("FAIL rst_ir: got %h want 0", dut.ir_r); end
        vectors++; if (dut.mar_r !== 32'd0) begin miscompares++; $display("FAIL rst_mar: got %h want 0", dut.mar_r); end
        vectors++; if (dut.mdr_r !== 32'd0) begin miscompares++; $display("FAIL rst_mdr: got %h want 0", dut.mdr_r); end
        vectors++; if (dut.y_r !== 32'd0) begin miscompares++; $display("FAIL rst_y: got %h want 0", dut.y_r); end
        vectors++; if (dut.z_r !== 64'd0) begin miscompares++; $display("FAIL rst_z: got %h want 0", dut.z_r); end
        vectors++; if ({dut.hi_r, dut.lo_r} !== 64'd0) begin miscompares++; $display("FAIL rst_hilo: got %h want 0", {dut.hi_r, dut.lo_r}); end
        vectors++; if ({dut.regs_r[0], dut.regs_r[8]} !== 64'd0) begin miscompares++; $display("FAIL rst_r0_r8: got %h want 0", {dut.regs_r[0], dut.regs_r[8]}); end
        #1; clear = 0;
        #1;
        vectors++; if (dut.bus_s !== 32'd0) begin miscompares++; $display("FAIL bus_idle: got %h want 0", dut.bus_s); end
    endtask

    task automatic test_fetch();
        build_z(32'hC100_0000);
        begin_cyc(); Zlowout = 1; MDRin = 1; end_cyc();
        begin_cyc(); MARin = 1; end_cyc();
        begin_cyc(); write = 1; end_cyc();
        vectors++; if (dut.ram_r[0] !== 32'hC100_0000) begin miscompares++; $display("FAIL ram0_write: got %h want %h", dut.ram_r[0], 32'hC100_0000); end
        begin_cyc(); IncPC = 1; MDRin = 1; end_cyc();
        begin_cyc(); PCout = 1; MARin = 1; end_cyc();
        begin_cyc(); PCin = 1; end_cyc();
        begin_cyc(); PCout = 1; MARin = 1; IncPC = 1; end_cyc();
        vectors++; if (dut.mar_r !== 32'd0) begin miscompares++; $display("FAIL t0_mar: got %h want 0", dut.mar_r); end
        vectors++; if (dut.pc_r !== 32'd1) begin miscompares++; $display("FAIL t0_pc: got %h want 1", dut.pc_r); end
        begin_cyc(); read = 1; MDRin = 1; PCin = 1; end_cyc();
        vectors++; if (dut.mdr_r !== 32'hC100_0000) begin miscompares++; $display("FAIL t1_mdr: got %h want %h", dut.mdr_r, 32'hC100_0000); end
        vectors++; if (dut.pc_r !== 32'd0) begin miscompares++; $display("FAIL t1_pc: got %h want 0", dut.pc_r); end
        begin_cyc(); MDRout = 1; IRin = 1; end_cyc();
        vectors++; if (dut.ir_r !== 32'hC100_0000) begin miscompares++; $display("FAIL t2_ir: got %h want %h", dut.ir_r, 32'hC100_0000); end
    endtask

    task automatic test_mfhi_mflo();
        build_z(32'h0000_1234);
        begin_cyc(); Zlowout = 1; MDRin = 1; end_cyc();
        begin_cyc(); MDRout = 1; HIin = 1; end_cyc();
        begin_cyc(); HIout = 1; Gra = 1; Rin = 1; end_cyc();
        vectors++; if (dut.regs_r[2] !== 32'h0000_1234) begin miscompares++; $display("FAIL mfhi_r2: got %h want %h", dut.regs_r[2], 32'h1234); end
        build_z(32'h0000_5678);
        begin_cyc(); Zlowout = 1; MDRin = 1; end_cyc();
        begin_cyc(); MDRout = 1; LOin = 1; end_cyc();
        begin_cyc(); HIout = 1; LOout = 1; #1;
        vectors++; if (dut.bus_s !== 32'h0000_1234) begin miscompares++; $display("FAIL hi_over_lo: got %h want %h", dut.bus_s, 32'h1234); end
        end_cyc();
        begin_cyc(); LOout = 1; Gra = 1; Rin = 1; end_cyc();
        vectors++; if (dut.regs_r[2] !== 32'h0000_5678) begin miscompares++; $display("FAIL mflo_r2: got %h want %h", dut.regs_r[2], 32'h5678); end
        begin_cyc(); Gra = 1; Rout = 1; #1;
        vectors++; if (dut.bus_s !== 32'h0000_5678) begin miscompares++; $display("FAIL r2_rout: got %h want %h", dut.bus_s, 32'h5678); end
        end_cyc();
    endtask

    task automatic test_alu();
        build_z(32'hFFFF_FFFD);
        begin_cyc(); Zlowout = 1; HIin = 1; end_cyc();
        build_z(32'd7);
        begin_cyc(); Zlowout = 1; Yin = 1; end_cyc();
        begin_cyc(); HIout = 1; opcode = 5'b10000; Zin = 1; end_cyc();
        vectors++; if (dut.z_r !== 64'hFFFF_FFFF_FFFF_FFEB) begin miscompares++; $display("FAIL mul: got %h want %h", dut.z_r, 64'hFFFF_FFFF_FFFF_FFEB); end
        begin_cyc(); HIout = 1; opcode = 5'b01111; Zin = 1; end_cyc();
        vectors++; if (dut.z_r !== 64'h0000_0001_FFFF_FFFE) begin miscompares++; $display("FAIL div: got %h want %h", dut.z_r, 64'h0000_0001_FFFF_FFFE); end
        begin_cyc(); opcode = 5'b01111; Zin = 1; end_cyc();
        vectors++; if (dut.z_r !== 64'h0000_0007_FFFF_FFFF) begin miscompares++; $display("FAIL div0: got %h want %h", dut.z_r, 64'h0000_0007_FFFF_FFFF); end
        build_z(32'd4);
        begin_cyc(); Zlowout = 1; LOin = 1; end_cyc();
        build_z(32'h0000_000F);
        begin_cyc(); Zlowout = 1; Yin = 1; end_cyc();
        begin_cyc(); LOout = 1; opcode = 5'b00111; Zin = 1; end_cyc();
        vectors++; if (dut.z_r !== 64'h0000_0000_F000_0000) begin miscompares++; $display("FAIL ror: got %h want %h", dut.z_r, 64'hF000_0000); end
        begin_cyc(); LOout = 1; opcode = 5'b00100; Zin = 1; end_cyc();
        vectors++; if (dut.z_r !== 64'h0000_0000_0000_000B) begin miscompares++; $display("FAIL sub: got %h want %h", dut.z_r, 64'hB); end
        begin_cyc(); LOout = 1; opcode = 5'b10001; Zin = 1; end_cyc();
        vectors++; if (dut.z_r !== 64'h0000_0000_FFFF_FFFC) begin miscompares++; $display("FAIL neg: got %h want %h", dut.z_r, 64'hFFFF_FFFC); end
    endtask

    task automatic test_baout();
        build_z(32'd5);
        begin_cyc(); Zlowout = 1; Grb = 1; Rin = 1; end_cyc();
        begin_cyc(); Grb = 1; BAout = 1; #1;
        vectors++; if (dut.bus_s !== 32'd0) begin miscompares++; $display("FAIL baout_r0: got %h want 0", dut.bus_s); end
        end_cyc();
        begin_cyc(); Grb = 1; Rout = 1; #1;
        vectors++; if (dut.bus_s !== 32'd5) begin miscompares++; $display("FAIL rout_r0: got %h want 5", dut.bus_s); end
        end_cyc();
    endtask

    task automatic test_store();
        build_z(32'h0000_DEAD);
        begin_cyc(); Zlowout = 1; MDRin = 1; end_cyc();
        build_z(32'd10);
        begin_cyc(); Zlowout = 1; MARin = 1; end_cyc();
        begin_cyc(); write = 1; end_cyc();
        vectors++; if (dut.ram_r[10] !== 32'h0000_DEAD) begin miscompares++; $display("FAIL st_ram10: got %h want %h", dut.ram_r[10], 32'hDEAD); end
        begin_cyc(); MDRin = 1; end_cyc();
        begin_cyc(); read = 1; MDRin = 1; end_cyc();
        vectors++; if (dut.mdr_r !== 32'h0000_DEAD) begin miscompares++; $display("FAIL ld_mdr: got %h want %h", dut.mdr_r, 32'hDEAD); end
        begin_cyc(); MDRin = 1; end_cyc();
        begin_cyc(); read = 1; write = 1; MDRin = 1; end_cyc();
        vectors++; if (dut.mdr_r !== 32'h0000_DEAD) begin miscompares++; $display("FAIL rw_old_mdr: got %h want %h", dut.mdr_r, 32'hDEAD); end
        vectors++; if (dut.ram_r[10] !== 32'd0) begin miscompares++; $display("FAIL rw_ram10: got %h want 0", dut.ram_r[10]); end
    endtask

    task automatic test_cout();
        build_z(32'h0007_FFFF);
        begin_cyc(); Zlowout = 1; IRin = 1; end_cyc();
        begin_cyc(); Cout = 1; #1;
        vectors++; if (dut.bus_s !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL cout_neg: got %h want %h", dut.bus_s, 32'hFFFF_FFFF); end
        end_cyc();
        build_z(32'hF803_FFFF);
        begin_cyc(); Zlowout = 1; IRin = 1; end_cyc();
        begin_cyc(); Cout = 1; #1;
        vectors++; if (dut.bus_s !== 32'h0003_FFFF) begin miscompares++; $display("FAIL cout_pos: got %h want %h", dut.bus_s, 32'h0003_FFFF); end
        end_cyc();
    endtask

    task automatic test_r8();
        build_z(32'h0004_0000);
        begin_cyc(); Zlowout = 1; IRin = 1; end_cyc();
        build_z(32'h0000_ABCD);
        begin_cyc(); Zlowout = 1; Grc = 1; Rin = 1; R8_RAin = 1; end_cyc();
        vectors++; if (dut.regs_r[8] !== 32'h0000_ABCD) begin miscompares++; $display("FAIL r8_both: got %h want %h", dut.regs_r[8], 32'hABCD); end
        build_z(32'h0000_1357);
        begin_cyc(); Zlowout = 1; R8_RAin = 1; end_cyc();
        vectors++; if (dut.regs_r[8] !== 32'h0000_1357) begin miscompares++; $display("FAIL r8_ra: got %h want %h", dut.regs_r[8], 32'h1357); end
        vectors++; if (dut.regs_r[7] !== 32'd0) begin miscompares++; $display("FAIL r7_untouched: got %h want 0", dut.regs_r[7]); end
    endtask

    task automatic test_pc();
        build_z(32'hFFFF_FFFF);
        begin_cyc(); Zlowout = 1; PCin = 1; IncPC = 1; end_cyc();
        vectors++; if (dut.pc_r !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL pcin_prio: got %h want %h", dut.pc_r, 32'hFFFF_FFFF); end
        begin_cyc(); IncPC = 1; end_cyc();
        vectors++; if (dut.pc_r !== 32'd0) begin miscompares++; $display("FAIL pc_wrap: got %h want 0", dut.pc_r); end
    endtask

    initial begin
        clr_ctrl();
        clear = 1'b1;
        #12;
        clear = 1'b0;
        test_reset();
        test_fetch();
        test_mfhi_mflo();
        test_alu();
        test_baout();
        test_store();
        test_cout();
        test_r8();
        test_pc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
